// File: rtl/mux_scan_nx1.sv
// ---------------------------------------------------------------------------
// mux_scan_nx1
//
// Registered N_CH-channel, W-bit multiplexer. It has two modes of operation:
//   - manual: the channel follows i_sel (out-of-range requests are ignored)
//   - scan:   the channel advances round-robin, dwelling DIV cycles on each
//             channel; i_hold freezes the dwell counter and the channel.
// Data, channel index and one-hot enable are registered on the same edge,
// so the three outputs always describe the same channel. There is no
// combinational path from any input to any output.
//
// Parameters:
//   N_CH  number of input channels (2..16)
//   W     width of each channel (1..32)
//   DIV   cycles spent on each channel in scan mode (1..65535)
//   SW    width of the channel index (derived, $clog2(N_CH))
//
// Ports:
//   i_clk        system clock, rising edge
//   i_rst        asynchronous, active-high reset
//   i_mode       0 = manual (use i_sel), 1 = scan
//   i_sel        requested channel in manual mode
//   i_hold       scan mode only: freezes dwell counter and channel
//   i_ent        flattened inputs, channel i at bits [i*W +: W]
//   o_out        registered data of the current channel
//   o_ch         registered current channel index
//   o_ch_onehot  registered one-hot of o_ch (all zero while in reset)
//   o_wrap       one-cycle pulse when a scan wraps from N_CH-1 to 0
// ---------------------------------------------------------------------------
module mux_scan_nx1 #(
    parameter int  N_CH = 4,
    parameter int  W    = 4,
    parameter int  DIV  = 4,
    localparam int SW   = $clog2(N_CH)
) (
    input  logic              i_clk,
    input  logic              i_rst,
    input  logic              i_mode,
    input  logic [SW-1:0]     i_sel,
    input  logic              i_hold,
    input  logic [N_CH*W-1:0] i_ent,
    output logic [W-1:0]      o_out,
    output logic [SW-1:0]     o_ch,
    output logic [N_CH-1:0]   o_ch_onehot,
    output logic              o_wrap
);

    // The dwell counter needs at least one bit even when DIV is 1.
    localparam int CW = (DIV > 1) ? $clog2(DIV) : 1;

    localparam logic [SW-1:0] CH_LAST  = SW'(N_CH - 1);
    localparam logic [CW-1:0] CNT_LAST = CW'(DIV - 1);

    logic [SW-1:0]   r_ch;
    logic [CW-1:0]   r_cnt;
    logic [W-1:0]    r_out;
    logic [N_CH-1:0] r_onehot;
    logic            r_wrap;

    logic [SW-1:0]   w_nxt;
    logic [CW-1:0]   w_cntNxt;
    logic            w_wrapNxt;
    logic [W-1:0]    w_data;
    logic [N_CH-1:0] w_onehot;

    // Next-channel selection.
    // Manual mode keeps the counter cleared so that a later switch to scan
    // starts a full dwell on the current channel. The >= comparisons (rather
    // than ==) keep the index inside 0..N_CH-1 even for non-power-of-two
    // channel counts, where the index register has unused encodings.
    always_comb begin
        w_nxt     = r_ch;
        w_cntNxt  = '0;
        w_wrapNxt = 1'b0;
        if (!i_mode) begin
            if (i_sel <= CH_LAST) begin
                w_nxt = i_sel;
            end
        end else if (i_hold) begin
            w_cntNxt = r_cnt;
        end else if (r_cnt >= CNT_LAST) begin
            w_cntNxt = '0;
            if (r_ch >= CH_LAST) begin
                w_nxt     = '0;
                w_wrapNxt = 1'b1;
            end else begin
                w_nxt = r_ch + SW'(1);
            end
        end else begin
            w_cntNxt = r_cnt + CW'(1);
        end
    end

    // Data slice and one-hot enable for the channel about to be loaded.
    // Both are derived from w_nxt so the registered outputs agree with each
    // other; the data is sampled from i_ent on the same edge.
    always_comb begin
        w_data   = '0;
        w_onehot = '0;
        for (int i = 0; i < N_CH; i++) begin
            if (w_nxt == SW'(i)) begin
                w_data      = i_ent[i*W +: W];
                w_onehot[i] = 1'b1;
            end
        end
    end

    // State and output registers. Reset clears everything, including the
    // one-hot, so a zero one-hot marks "no channel enabled yet".
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_ch     <= '0;
            r_cnt    <= '0;
            r_out    <= '0;
            r_onehot <= '0;
            r_wrap   <= 1'b0;
        end else begin
            r_ch     <= w_nxt;
            r_cnt    <= w_cntNxt;
            r_out    <= w_data;
            r_onehot <= w_onehot;
            r_wrap   <= w_wrapNxt;
        end
    end

    assign o_out       = r_out;
    assign o_ch        = r_ch;
    assign o_ch_onehot = r_onehot;
    assign o_wrap      = r_wrap;

endmodule

// File: tb/tb_mux_scan_nx1.sv
// ---------------------------------------------------------------------------
// tb_mux_scan_nx1
//
// Drives two instances of mux_scan_nx1 from the same control inputs:
//   dut0: N_CH=4, W=4, DIV=4  (power-of-two channel count, multi-cycle dwell)
//   dut1: N_CH=3, W=5, DIV=1  (non-power-of-two count, advance every cycle)
// A behavioural model (channel index plus cycles-elapsed on the channel)
// predicts every output after every rising edge. Directed sequences with
// hand-computed values come first, then randomized traffic.
// ---------------------------------------------------------------------------
module tb_mux_scan_nx1;

    localparam int N0 = 4;
    localparam int W0 = 4;
    localparam int D0 = 4;
    localparam int N1 = 3;
    localparam int W1 = 5;
    localparam int D1 = 1;

    logic        clk = 1'b0;
    logic        rst;
    logic        mode;
    logic [1:0]  sel;
    logic        hold;
    logic [15:0] ent0;
    logic [14:0] ent1;

    logic [3:0]  out0;
    logic [1:0]  ch0;
    logic [3:0]  oh0;
    logic        wrap0;
    logic [4:0]  out1;
    logic [1:0]  ch1;
    logic [2:0]  oh1;
    logic        wrap1;

    int testsRun    = 0;
    int testsFailed = 0;

    always #5 clk = ~clk;

    mux_scan_nx1 #(.N_CH(N0), .W(W0), .DIV(D0)) dut0 (
        .i_clk(clk), .i_rst(rst), .i_mode(mode), .i_sel(sel), .i_hold(hold),
        .i_ent(ent0), .o_out(out0), .o_ch(ch0), .o_ch_onehot(oh0), .o_wrap(wrap0)
    );

    mux_scan_nx1 #(.N_CH(N1), .W(W1), .DIV(D1)) dut1 (
        .i_clk(clk), .i_rst(rst), .i_mode(mode), .i_sel(sel), .i_hold(hold),
        .i_ent(ent1), .o_out(out1), .o_ch(ch1), .o_ch_onehot(oh1), .o_wrap(wrap1)
    );

    // Model state: which channel is shown, how many cycles of the current
    // dwell have elapsed, whether a wrap happened this edge, and whether any
    // edge has happened since reset.
    typedef struct {
        int ch;
        int elapsed;
        bit wrap;
        bit live;
    } modelT;

    modelT m0;
    modelT m1;
    logic [31:0] expOut0, expOut1;

    function automatic modelT stepModel(modelT s, int nCh, int div, bit m, int sl, bit h);
        modelT n = s;
        n.live = 1'b1;
        n.wrap = 1'b0;
        if (!m) begin
            if (sl < nCh) n.ch = sl;
            n.elapsed = 0;
        end else if (!h) begin
            n.elapsed = s.elapsed + 1;
            if (n.elapsed == div) begin
                n.elapsed = 0;
                n.wrap    = (s.ch == nCh - 1);
                n.ch      = (s.ch + 1) % nCh;
            end
        end
        return n;
    endfunction

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        testsRun++;
        if (act !== exp) begin
            testsFailed++;
            $display("[TB] FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
        end
    endtask

    // Inputs change only on the falling edge, away from the sampling edge.
    task automatic applyStimulus(input bit m, input logic [1:0] s, input bit h,
                                 input logic [15:0] e0, input logic [14:0] e1);
        @(negedge clk);
        mode = m;
        sel  = s;
        hold = h;
        ent0 = e0;
        ent1 = e1;
    endtask

    task automatic waitEdge();
        @(posedge clk);
        #2;
    endtask

    // Per-cycle comparison of both instances against the model.
    always @(posedge clk) begin
        if (rst) begin
            m0 = '{default: 0};
            m1 = '{default: 0};
            expOut0 = '0;
            expOut1 = '0;
        end else begin
            m0 = stepModel(m0, N0, D0, mode, int'(sel), hold);
            m1 = stepModel(m1, N1, D1, mode, int'(sel), hold);
            expOut0 = 32'((ent0 >> (W0 * m0.ch)) & 16'hF);
            expOut1 = 32'((ent1 >> (W1 * m1.ch)) & 15'h1F);
        end
        #1;
        checkOutput("out0",  32'(out0),  expOut0);
        checkOutput("ch0",   32'(ch0),   32'(m0.ch));
        checkOutput("oh0",   32'(oh0),   m0.live ? (32'd1 << m0.ch) : 32'd0);
        checkOutput("wrap0", 32'(wrap0), 32'(m0.wrap));
        checkOutput("out1",  32'(out1),  expOut1);
        checkOutput("ch1",   32'(ch1),   32'(m1.ch));
        checkOutput("oh1",   32'(oh1),   m1.live ? (32'd1 << m1.ch) : 32'd0);
        checkOutput("wrap1", 32'(wrap1), 32'(m1.wrap));
    end

    // Watchdog so the run always ends on its own.
    initial begin
        #1_000_000;
        testsFailed++;
        $display("[TB] FAIL watchdog: got timeout expected completion");
        $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
        $finish;
    end

    // Directed sequences followed by randomized traffic.
    initial begin
        logic [14:0] e1Fixed;
        int shown;
        bit sawWrap;

        e1Fixed = {5'h1F, 5'h12, 5'h01};
        rst  = 1'b1;
        mode = 1'b0;
        sel  = '0;
        hold = 1'b0;
        ent0 = '0;
        ent1 = '0;

        waitEdge();
        checkOutput("rst_out", 32'(out0), 32'h0);
        checkOutput("rst_oh",  32'(oh0),  32'h0);
        @(negedge clk) rst = 1'b0;

        // Manual select.
        applyStimulus(1'b0, 2'd2, 1'b0, 16'h4321, e1Fixed);
        waitEdge();
        checkOutput("man_out", 32'(out0), 32'h3);
        checkOutput("man_ch",  32'(ch0),  32'd2);
        checkOutput("man_oh",  32'(oh0),  32'b0100);
        applyStimulus(1'b0, 2'd2, 1'b0, 16'h4F21, e1Fixed);
        waitEdge();
        checkOutput("man_upd", 32'(out0), 32'hF);

        // Out-of-range select on the three-channel instance.
        applyStimulus(1'b0, 2'd1, 1'b0, 16'h4F21, e1Fixed);
        waitEdge();
        checkOutput("oor_ch1",  32'(ch1),  32'd1);
        applyStimulus(1'b0, 2'd3, 1'b0, 16'h4F21, e1Fixed);
        waitEdge();
        checkOutput("oor_keep", 32'(ch1),  32'd1);
        checkOutput("oor_data", 32'(out1), 32'h12);
        checkOutput("oor_d0ch", 32'(ch0),  32'd3);
        applyStimulus(1'b0, 2'd0, 1'b0, 16'h4F21, e1Fixed);
        waitEdge();
        checkOutput("oor_sel0", 32'(ch1),  32'd0);
        checkOutput("oor_d0",   32'(out1), 32'h01);

        // Scan with DIV=4 from channel 0: edge k shows channel k/4 mod 4.
        applyStimulus(1'b0, 2'd0, 1'b0, 16'hDCBA, e1Fixed);
        waitEdge();
        applyStimulus(1'b1, 2'd0, 1'b0, 16'hDCBA, e1Fixed);
        for (int k = 1; k <= 32; k++) begin
            @(posedge clk);
            #2;
            checkOutput("scan_out",  32'(out0),  32'hA + 32'((k / 4) % 4));
            checkOutput("scan_wrap", 32'(wrap0), 32'(k % 16 == 0));
        end

        // Hold for 3 cycles on channel 1 stretches its dwell to 7 cycles.
        shown   = 0;
        sawWrap = 1'b0;
        for (int j = 0; j < 20; j++) begin
            applyStimulus(j != 0, 2'd1, (j >= 2 && j <= 4), 16'hDCBA, e1Fixed);
            waitEdge();
            if (ch0 == 2'd1) shown++;
            if (wrap0) sawWrap = 1'b1;
            if (ch0 == 2'd2) break;
        end
        checkOutput("hold_len",  32'(shown),   32'd7);
        checkOutput("hold_next", 32'(ch0),     32'd2);
        checkOutput("hold_wrap", 32'(sawWrap), 32'd0);

        // Scan on channel 2 to cnt=2, drop to manual sel=0, then rescan.
        applyStimulus(1'b0, 2'd2, 1'b0, 16'hDCBA, e1Fixed);
        waitEdge();
        applyStimulus(1'b1, 2'd0, 1'b0, 16'hDCBA, e1Fixed);
        waitEdge();
        waitEdge();
        applyStimulus(1'b0, 2'd0, 1'b0, 16'hDCBA, e1Fixed);
        waitEdge();
        checkOutput("msw_ch", 32'(ch0), 32'd0);
        shown = 1;
        for (int j = 0; j < 20; j++) begin
            applyStimulus(1'b1, 2'd0, 1'b0, 16'hDCBA, e1Fixed);
            waitEdge();
            if (ch0 != 2'd0) break;
            shown++;
        end
        checkOutput("msw_dwell", 32'(shown), 32'd4);
        checkOutput("msw_next",  32'(ch0),   32'd1);

        // Asynchronous reset mid-scan takes effect before any clock edge.
        applyStimulus(1'b1, 2'd0, 1'b0, 16'hFEDC, e1Fixed);
        waitEdge();
        @(negedge clk);
        #2 rst = 1'b1;
        #1;
        checkOutput("arst_out",  32'(out0),  32'h0);
        checkOutput("arst_ch",   32'(ch0),   32'h0);
        checkOutput("arst_oh",   32'(oh0),   32'h0);
        checkOutput("arst_wrap", 32'(wrap0), 32'h0);
        @(negedge clk) rst = 1'b0;

        // Randomized traffic: long mode stretches, frequent hold, rare reset.
        for (int r = 0; r < 1500; r++) begin
            bit nextMode;
            nextMode = ($urandom_range(0, 19) == 0) ? ~mode : mode;
            applyStimulus(nextMode, 2'($urandom_range(0, 3)), ($urandom_range(0, 4) == 0),
                          16'($urandom), 15'($urandom));
            rst = ($urandom_range(0, 99) == 0);
        end
        @(negedge clk) rst = 1'b0;
        waitEdge();
        waitEdge();

        $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
        $finish;
    end

endmodule

// File: doc/mux_scan_nx1.md
# mux_scan_nx1

Registered N-channel, W-bit multiplexer with two modes: manual select, or automatic round-robin scan at a programmable dwell time. It generalises the 4x1 4-bit combinational mux used in the datapath and is the front end for time-multiplexed outputs such as display-digit scanning. Output data, channel index and one-hot channel enable are registered together, so they are always mutually consistent.

## Interface
- N_CH, 4, number of input channels (2..16)
- W, 4, width of each channel in bits (1..32)
- DIV, 4, clock cycles spent on each channel in scan mode (1..65535)
- SW (derived, not overridable), $clog2(N_CH), width of channel index
- clk  in  1  system clock, rising edge
- rst  in  1  asynchronous, active-high reset
- mode  in  1  0 = manual (use sel), 1 = scan
- sel  in  SW  requested channel in manual mode
- hold  in  1  scan mode only: freezes dwell counter and channel
- ent  in  N_CH*W  flattened inputs; channel i occupies bits [i*W+W-1 : i*W]
- out  out  W  registered data of the current channel
- ch  out  SW  registered current channel index
- ch_onehot  out  N_CH  registered one-hot of ch (bit ch set)
- wrap  out  1  one-cycle pulse when a scan wraps from channel N_CH-1 to 0

## Operation
- Internal state: channel register (SW bits), dwell counter cnt (width ceil(log2(DIV)), minimum 1 bit).
- Each rising edge computes the next index nxt, then loads ch<=nxt, out<=ent slice nxt (sampled this edge), ch_onehot<=1<<nxt.
- Manual mode (mode=0):
  - nxt = sel if sel < N_CH; otherwise nxt = ch (out-of-range sel is ignored, channel kept).
  - cnt held at 0; hold ignored; wrap=0.
- Scan mode (mode=1):
  - hold=1: cnt and ch unchanged; out still refreshes from ent of ch; wrap=0.
  - hold=0, cnt < DIV-1: cnt<=cnt+1, nxt = ch.
  - hold=0, cnt == DIV-1: cnt<=0, nxt = (ch==N_CH-1) ? 0 : ch+1. When ch==N_CH-1, wrap<=1 for that cycle.
  - DIV=1: channel advances every cycle.
- Mode changes:
  - Manual->scan: scan starts from the current ch with cnt=0, so the first dwell is a full DIV cycles.
  - Scan->manual: cnt cleared the same edge; ch follows sel from that edge on.
- Non-power-of-two N_CH: index never leaves 0..N_CH-1 in either mode.
- Arithmetic is unsigned. No combinational path from any input to any output.

## Timing
- Reset (asynchronous assert, effective immediately): ch=0, cnt=0, out=0, ch_onehot=0, wrap=0. Release is synchronised by the user; the first edge after release loads normal values (ch_onehot becomes nonzero).
- Latency: ent/sel -> out/ch/ch_onehot is 1 clock.
- Scan period: each channel is presented for exactly DIV cycles; full rotation is N_CH*DIV cycles; wrap pulses once per rotation, in the first cycle of channel 0.
- hold asserted for k cycles stretches the current dwell by exactly k cycles.
- Reset mid-scan: all state returns to reset values immediately; the scan restarts at channel 0 with cnt=0.

## Test plan
- Reset: assert rst mid-operation with ent=0xFEDC (N_CH=4, W=4) -> out=0, ch=0, ch_onehot=0000, wrap=0 without waiting for a clock edge.
- Manual select: mode=0, ent=0x4321, sel=2 -> after 1 edge out=0x3, ch=2, ch_onehot=0100; changing ent to 0x4F21 gives out=0xF on the next edge.
- Scan, DIV=4: mode=1, hold=0, ent=0xDCBA -> out sequence A,A,A,A,B,B,B,B,C..,D..,A; wrap high for exactly one cycle at each return to 0xA; period 16 cycles.
- Hold: during a scan on channel 1, assert hold for 3 cycles -> channel 1 is shown for 7 cycles total, then channel 2; no wrap while holding.
- Out-of-range select: N_CH=3, mode=0, sel=1 then sel=3 -> ch stays 1, out stays channel 1 data; sel=0 -> ch=0.
- Mode switch: scan on channel 2 with cnt=2, set mode=0 with sel=0 -> ch=0 next edge; return to mode=1 -> channel 0 held for full DIV cycles before channel 1.
